// File: rtl/sal_rd_resp_pkg.sv
// rtl/sal_rd_resp_pkg.sv - shared types for the read-response arbiter (SAL_RD_RESP_ID_CHECK_EN aware)
package sal_rd_resp_pkg;

    localparam int RD_ID_W   = 4;
    localparam int RD_DATA_W = 64;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    typedef struct packed {
        logic [RD_ID_W-1:0]   id;
        logic [RD_DATA_W-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } rd_beat_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sal_skid_buf.sv
// rtl/sal_skid_buf.sv - 2-entry valid/ready buffer, head entry drives the output
module sal_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] s_tdata_i,
    input  logic         s_tvalid_i,
    output logic         s_tready_o,
    output logic [W-1:0] m_tdata_o,
    output logic         m_tvalid_o,
    input  logic         m_tready_i
);

    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    assign s_tready_o = (cnt_q != 2'd2);
    assign m_tvalid_o = (cnt_q != 2'd0);
    assign m_tdata_o  = head_q;
    assign push       = s_tvalid_i & s_tready_o;
    assign pop        = m_tvalid_o & m_tready_i;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    head_d = s_tdata_i;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = s_tdata_i;
                end else if (push) begin
                    tail_d = s_tdata_i;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d = 2'd0;
                end
            end
            default: begin
                // Full: input is stalled, so only a pop can happen here.
                if (pop) begin
                    head_d = tail_q;
                    cnt_d  = 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sal_rd_resp_arbiter.sv
// rtl/sal_rd_resp_arbiter.sv - per-burst round-robin merge of bank read beats onto one R channel; option SAL_RD_RESP_ID_CHECK_EN
module sal_rd_resp_arbiter
    import sal_rd_resp_pkg::*;
#(
    parameter int BK_CNT     = 4,
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [BK_CNT-1:0]              bk_rvalid,
    output logic [BK_CNT-1:0]              bk_rready,
    input  logic [BK_CNT*ID_WIDTH-1:0]     bk_rid,
    input  logic [BK_CNT*LEN_WIDTH-1:0]    bk_rlen,
    input  logic [BK_CNT*DATA_WIDTH-1:0]   bk_rdata,
    output logic [ID_WIDTH-1:0]            rid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rlast,
    output logic                           rvalid,
    input  logic                           rready,
    output logic                           err
);

    localparam int GW = (BK_CNT > 1) ? $clog2(BK_CNT) : 1;

    state_e                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick;
    logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d, len_q, len_d;
    logic [ID_WIDTH-1:0]    id_q, id_d, cur_id;
    logic [LEN_WIDTH-1:0]   cur_len, eff_len;
    logic [DATA_WIDTH-1:0]  cur_data;
    logic                   pick_vld, first_beat, beat_last, skid_rdy, accept, id_bad;
    rd_beat_t               beat_in, beat_out;

    // Scan from the highest offset down so the entry closest to rr_ptr wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = BK_CNT - 1; i >= 0; i--) begin
            if (bk_rvalid[(int'(rr_ptr_q) + i) % BK_CNT]) begin
                pick     = GW'((int'(rr_ptr_q) + i) % BK_CNT);
                pick_vld = 1'b1;
            end
        end
    end

    assign cur_id     = bk_rid[int'(grant_q)*ID_WIDTH +: ID_WIDTH];
    assign cur_len    = bk_rlen[int'(grant_q)*LEN_WIDTH +: LEN_WIDTH];
    assign cur_data   = bk_rdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign first_beat = (beat_cnt_q == '0);
    assign eff_len    = first_beat ? cur_len : len_q;
    assign beat_last  = (beat_cnt_q == eff_len);
    assign accept     = (state_q == BURST) & bk_rvalid[grant_q] & skid_rdy;

    always_comb begin
        bk_rready = '0;
        if (state_q == BURST && skid_rdy) begin
            bk_rready[grant_q] = 1'b1;
        end
    end

`ifdef SAL_RD_RESP_ID_CHECK_EN
    logic err_q, err_d;
    assign id_bad = !first_beat && (cur_id != id_q);
    assign err_d  = err_q | (accept & id_bad);
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign id_bad = 1'b0;
    assign err    = 1'b0;
`endif

    always_comb begin
        beat_in      = '0;
        beat_in.id   = first_beat ? cur_id : id_q;
        beat_in.data = cur_data;
        beat_in.resp = id_bad ? RESP_SLVERR : RESP_OKAY;
        beat_in.last = beat_last;
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        id_d       = id_q;
        if (state_q == IDLE) begin
            if (pick_vld) begin
                grant_d = pick;
                state_d = BURST;
            end
        end else if (accept) begin
            if (first_beat) begin
                id_d  = cur_id;
                len_d = cur_len;
            end
            if (beat_last) begin
                beat_cnt_d = '0;
                rr_ptr_d   = (grant_q == GW'(BK_CNT - 1)) ? '0 : grant_q + 1'b1;
                state_d    = IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            id_q       <= id_d;
        end
    end

    sal_skid_buf #(
        .W($bits(rd_beat_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_tdata_i (beat_in),
        .s_tvalid_i(accept),
        .s_tready_o(skid_rdy),
        .m_tdata_o (beat_out),
        .m_tvalid_o(rvalid),
        .m_tready_i(rready)
    );

    assign rid   = beat_out.id;
    assign rdata = beat_out.data;
    assign rresp = beat_out.resp;
    assign rlast = beat_out.last;

endmodule

// File: tb/tb_sal_rd_resp_arbiter.sv
// tb/tb_sal_rd_resp_arbiter.sv - bench for sal_rd_resp_arbiter against a burst-level round-robin model
module tb_sal_rd_resp_arbiter;
    localparam int BK  = 4;
    localparam int IDW = 4;
    localparam int DW  = 64;
    localparam int LW  = 4;
`ifdef SAL_RD_RESP_ID_CHECK_EN
    localparam bit ID_CHK = 1'b1;
`else
    localparam bit ID_CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [BK-1:0]     bk_rvalid = '0;
    logic [BK-1:0]     bk_rready;
    logic [BK*IDW-1:0] bk_rid = '0;
    logic [BK*LW-1:0]  bk_rlen = '0;
    logic [BK*DW-1:0]  bk_rdata = '0;
    logic [IDW-1:0]    rid;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic              rlast, rvalid, err;
    logic              rready = 1'b0;

    always #5 clk = ~clk;

    sal_rd_resp_arbiter #(.BK_CNT(BK), .ID_WIDTH(IDW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .bk_rvalid(bk_rvalid), .bk_rready(bk_rready),
        .bk_rid(bk_rid), .bk_rlen(bk_rlen), .bk_rdata(bk_rdata),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready), .err(err)
    );

    typedef struct { logic [3:0] id; logic [3:0] len; logic [63:0] data; bit first; bit last; } bbeat_t;
    typedef struct { logic [3:0] id; logic [3:0] len; logic [63:0] base; int bad; } burst_t;
    typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } obeat_t;

    bbeat_t bq[BK][$];
    burst_t mq[BK][$];
    obeat_t exp_q[$];
    obeat_t held;
    int     m_ptr, n_chk, n_pass, cyc, n_acc;
    int     first_acc_cyc, first_rv_cyc, last_end_cyc, gap, rr_mode;
    bit     exp_err, gap_en, hold;

    task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic add_burst(int b, logic [3:0] id, logic [3:0] len, logic [63:0] base, int bad);
        burst_t t;
        bbeat_t x;
        t.id = id; t.len = len; t.base = base; t.bad = bad;
        mq[b].push_back(t);
        for (int k = 0; k <= int'(len); k++) begin
            x.id    = (k == bad) ? (id ^ 4'h2) : id;
            x.len   = len;
            x.data  = base + 64'(k);
            x.first = (k == 0);
            x.last  = (k == int'(len));
            bq[b].push_back(x);
        end
    endtask

    // Whole bursts are granted in round-robin order among banks with work pending.
    task automatic build_expected();
        burst_t t;
        obeat_t o;
        int     b;
        while (1) begin
            b = -1;
            for (int i = 0; i < BK; i++) begin
                if (b < 0 && mq[(m_ptr + i) % BK].size() > 0) b = (m_ptr + i) % BK;
            end
            if (b < 0) break;
            t = mq[b].pop_front();
            for (int k = 0; k <= int'(t.len); k++) begin
                o.id   = t.id;
                o.data = t.base + 64'(k);
                o.resp = (ID_CHK && k == t.bad) ? 2'b10 : 2'b00;
                o.last = (k == int'(t.len));
                exp_q.push_back(o);
            end
            if (ID_CHK && t.bad >= 0) exp_err = 1'b1;
            m_ptr = (b + 1) % BK;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < BK; i++) begin
            bk_rvalid[i] = 1'b0;
            if (bq[i].size() > 0) begin
                if (!(gap_en && !bq[i][0].first && $urandom_range(3) == 0)) begin
                    bk_rvalid[i]            = 1'b1;
                    bk_rid[i*IDW +: IDW]    = bq[i][0].id;
                    bk_rlen[i*LW +: LW]     = bq[i][0].len;
                    bk_rdata[i*DW +: DW]    = bq[i][0].data;
                end
            end
        end
        rready = (rr_mode == 2) ? ($urandom_range(3) != 0) : (rr_mode == 1);
    endtask

    task automatic step();
        obeat_t    o;
        bit [BK-1:0] acc;
        acc = '0;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < BK; i++) begin
            if (rst_n && bk_rvalid[i] && bk_rready[i]) begin
                acc[i] = 1'b1;
                n_acc++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                if (bq[i][0].first) gap = cyc - last_end_cyc;
                if (bq[i][0].last) last_end_cyc = cyc;
            end
        end
        if (rst_n) begin
            if (hold) begin
                chk("hold_rvalid", 64'(rvalid), 64'(1));
                chk("hold_rid", 64'(rid), 64'(held.id));
                chk("hold_rdata", rdata, held.data);
                chk("hold_rlast", 64'(rlast), 64'(held.last));
                hold = 1'b0;
            end
            if (rvalid) begin
                if (first_rv_cyc < 0) first_rv_cyc = cyc;
                if (rready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(rvalid), 64'(0));
                    end else begin
                        o = exp_q.pop_front();
                        chk("rid", 64'(rid), 64'(o.id));
                        chk("rdata", rdata, o.data);
                        chk("rresp", 64'(rresp), 64'(o.resp));
                        chk("rlast", 64'(rlast), 64'(o.last));
                    end
                end else begin
                    hold      = 1'b1;
                    held.id   = rid;
                    held.data = rdata;
                    held.last = rlast;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < BK; i++) if (acc[i]) void'(bq[i].pop_front());
        drive();
    endtask

    task automatic flush();
        for (int i = 0; i < BK; i++) begin
            bq[i].delete();
            mq[i].delete();
        end
        exp_q.delete();
        m_ptr = 0; exp_err = 1'b0; hold = 1'b0; last_end_cyc = -100;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush();
        drive();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; n_acc = 0; gap = 0;
        rr_mode = 1; gap_en = 1'b0;
        do_reset();
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_bk_rready", 64'(bk_rready), 64'(0));
        chk("rst_rid", 64'(rid), 64'(0));
        chk("rst_rdata", rdata, 64'(0));
        chk("rst_rlast", 64'(rlast), 64'(0));
        chk("rst_rresp", 64'(rresp), 64'(0));
        chk("rst_err", 64'(err), 64'(0));

        first_acc_cyc = -1; first_rv_cyc = -1;
        add_burst(2, 4'd5, 4'd3, 64'hA0, -1);
        build_expected(); drive(); drain(100);
        chk("t1_latency", 64'(first_rv_cyc - first_acc_cyc), 64'(1));

        add_burst(0, 4'd1, 4'd1, 64'hB0, -1);
        add_burst(1, 4'd2, 4'd1, 64'hC0, -1);
        build_expected(); drive(); drain(100);
        chk("t2_bubble", 64'(gap), 64'(2));

        add_burst(0, 4'd3, 4'd0, 64'hD0, -1);
        add_burst(2, 4'd7, 4'd0, 64'hE0, -1);
        build_expected(); drive(); drain(100);

        add_burst(1, 4'd9, 4'd3, 64'hF0, -1);
        build_expected(); drive();
        n_acc = 0;
        for (int n = 0; n < 50 && n_acc < 2; n++) step();
        chk("t5_two_beats", 64'(n_acc), 64'(2));
        rst_n = 1'b0;
        flush();
        drive();
        step();
        chk("t5_rst_rvalid", 64'(rvalid), 64'(0));
        chk("t5_rst_bk_rready", 64'(bk_rready), 64'(0));
        rst_n = 1'b1;
        add_burst(3, 4'd11, 4'd1, 64'h300, -1);
        add_burst(0, 4'd12, 4'd1, 64'h400, -1);
        build_expected(); drive(); drain(100);

        add_burst(3, 4'hA, 4'd0, 64'h55, -1);
        build_expected(); drive(); drain(100);

        rr_mode = 0;
        add_burst(0, 4'hC, 4'd7, 64'h100, -1);
        build_expected(); drive();
        n_acc = 0;
        repeat (12) step();
        chk("t4_accepted", 64'(n_acc), 64'(2));
        chk("t4_bk_rready", 64'(bk_rready), 64'(0));
        chk("t4_rvalid", 64'(rvalid), 64'(1));
        chk("t4_rdata", rdata, exp_q[0].data);
        rr_mode = 1;
        drive(); drain(200);

        rr_mode = 2; gap_en = 1'b1;
        for (int b = 0; b < BK; b++) begin
            for (int j = 0; j < 3; j++) begin
                add_burst(b, 4'($urandom), 4'($urandom_range(7)), {$urandom, $urandom}, -1);
            end
        end
        build_expected(); drive(); drain(3000);
        chk("rand_err", 64'(err), 64'(exp_err));
        rr_mode = 1; gap_en = 1'b0;

        add_burst(1, 4'd4, 4'd2, 64'h200, 1);
        build_expected(); drive(); drain(100);
        chk("t6_err", 64'(err), 64'(exp_err));
        repeat (3) step();
        chk("t6_err_sticky", 64'(err), 64'(ID_CHK));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
